// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider: one 32/32 divide per 33 cycles, {quotient, remainder} out.
// Build option: define ITER_DIV_HOLD_RESULT_EN to hold DONE and m_axis_dout_tvalid until the next accept.
module iter_div #(
   parameter int SIGNED = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] s_axis_dividend_tdata,
   input  logic        s_axis_dividend_tvalid,
   output logic        s_axis_dividend_tready,
   input  logic [31:0] s_axis_divisor_tdata,
   input  logic        s_axis_divisor_tvalid,
   output logic        s_axis_divisor_tready,
   output logic [63:0] m_axis_dout_tdata,
   output logic        m_axis_dout_tvalid
);
   // state   | meaning
   // ST_IDLE | waiting for a joint dividend/divisor handshake
   // ST_BUSY | one restoring step per edge, 32 edges
   // ST_DONE | result registered; a new accept may start directly
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [31:0] rem_q, quo_q, dvsr_q;
   logic        q_neg_q, r_neg_q, dz_q;
   logic [63:0] dout_q;
   logic        tready_q, tvalid_q;

   logic        accept;
   logic        dd_neg, dv_neg;
   logic [31:0] dd_abs, dv_abs;
   logic [32:0] sh_rem, trial;
   logic [31:0] rem_n, quo_n, q_fin, r_fin;

   assign accept = (state_q != ST_BUSY) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

   assign dd_neg = (SIGNED != 0) && s_axis_dividend_tdata[31];
   assign dv_neg = (SIGNED != 0) && s_axis_divisor_tdata[31];
   assign dd_abs = dd_neg ? (~s_axis_dividend_tdata + 32'd1) : s_axis_dividend_tdata;
   assign dv_abs = dv_neg ? (~s_axis_divisor_tdata + 32'd1) : s_axis_divisor_tdata;

   // The shifted remainder needs a 33rd bit: rem < divisor can still double past 2^32.
   always_comb begin
      sh_rem = {rem_q, quo_q[31]};
      trial  = sh_rem - {1'b0, dvsr_q};
      rem_n  = sh_rem[31:0];
      quo_n  = {quo_q[30:0], 1'b0};
      if (!trial[32]) begin
         rem_n    = trial[31:0];
         quo_n[0] = 1'b1;
      end
   end

   // Divide by zero leaves rem = |dividend|, so re-signing it restores the original dividend.
   assign q_fin = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quo_n + 32'd1) : quo_n);
   assign r_fin = r_neg_q ? (~rem_n + 32'd1) : rem_n;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 6'd0;
         rem_q    <= 32'd0;
         quo_q    <= 32'd0;
         dvsr_q   <= 32'd0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         dz_q     <= 1'b0;
         dout_q   <= 64'd0;
         tready_q <= 1'b1;
         tvalid_q <= 1'b0;
      end else if (state_q == ST_BUSY) begin
         rem_q <= rem_n;
         quo_q <= quo_n;
         cnt_q <= cnt_q + 6'd1;
         if (cnt_q == 6'd31) begin
            dout_q   <= {q_fin, r_fin};
            tvalid_q <= 1'b1;
            tready_q <= 1'b1;
            state_q  <= ST_DONE;
         end
      end else if (accept) begin
         state_q  <= ST_BUSY;
         cnt_q    <= 6'd0;
         rem_q    <= 32'd0;
         quo_q    <= dd_abs;
         dvsr_q   <= dv_abs;
         q_neg_q  <= dd_neg ^ dv_neg;
         r_neg_q  <= dd_neg;
         dz_q     <= (s_axis_divisor_tdata == 32'd0);
         tready_q <= 1'b0;
         tvalid_q <= 1'b0;
      end else if (state_q == ST_DONE) begin
`ifdef ITER_DIV_HOLD_RESULT_EN
         tvalid_q <= 1'b1;
`else
         state_q  <= ST_IDLE;
         tvalid_q <= 1'b0;
`endif
      end
   end

   assign s_axis_dividend_tready = tready_q;
   assign s_axis_divisor_tready  = tready_q;
   assign m_axis_dout_tdata      = dout_q;
   assign m_axis_dout_tvalid     = tvalid_q;
endmodule

// File: tb/tb_iter_div.sv
// Bench for iter_div: signed and unsigned instances share stimulus and are checked every cycle
// against an arithmetic reference model, plus directed literal cases.
module tb_iter_div;
   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] dvd, dvs;
   logic        dvd_v, dvs_v;

   logic [1:0]       d_rdy_a, d_rdy_b, d_tv;
   logic [1:0][63:0] d_td;

   logic [1:0][5:0]  m_left;
   logic [1:0]       m_tv;
   logic [1:0][63:0] m_td, m_pend;

   int  errors = 0;
   int  checks = 0;
   bit  chk_en = 1'b0;

   always #5 clk = ~clk;

   iter_div #(.SIGNED(1)) u_sdiv (
      .clk(clk), .resetn(resetn),
      .s_axis_dividend_tdata(dvd), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(d_rdy_a[0]),
      .s_axis_divisor_tdata(dvs), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(d_rdy_b[0]),
      .m_axis_dout_tdata(d_td[0]), .m_axis_dout_tvalid(d_tv[0])
   );

   iter_div #(.SIGNED(0)) u_udiv (
      .clk(clk), .resetn(resetn),
      .s_axis_dividend_tdata(dvd), .s_axis_dividend_tvalid(dvd_v), .s_axis_dividend_tready(d_rdy_a[1]),
      .s_axis_divisor_tdata(dvs), .s_axis_divisor_tvalid(dvs_v), .s_axis_divisor_tready(d_rdy_b[1]),
      .m_axis_dout_tdata(d_td[1]), .m_axis_dout_tvalid(d_tv[1])
   );

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint la, lb, q, r;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (sgn) begin
         la = $signed(a);
         lb = $signed(b);
         q  = la / lb;
         r  = la % lb;
         return {q[31:0], r[31:0]};
      end
      return {a / b, a % b};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: accept starts a 32-edge countdown, result appears when it expires.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!resetn) begin
            m_left[i] <= 6'd0;
            m_tv[i]   <= 1'b0;
            m_td[i]   <= 64'd0;
         end else if (m_left[i] != 6'd0) begin
            m_left[i] <= m_left[i] - 6'd1;
            if (m_left[i] == 6'd1) begin
               m_td[i] <= m_pend[i];
               m_tv[i] <= 1'b1;
            end
         end else if (dvd_v && dvs_v) begin
            m_pend[i] <= ref_div(dvd, dvs, i == 0);
            m_left[i] <= 6'd32;
            m_tv[i]   <= 1'b0;
         end else begin
`ifndef ITER_DIV_HOLD_RESULT_EN
            m_tv[i] <= 1'b0;
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("tvalid[%0d]", i), {63'd0, d_tv[i]}, {63'd0, m_tv[i]});
            chk($sformatf("tdata[%0d]", i), d_td[i], m_td[i]);
            chk($sformatf("dvd_rdy[%0d]", i), {63'd0, d_rdy_a[i]}, {63'd0, m_left[i] == 6'd0});
            chk($sformatf("dvs_rdy[%0d]", i), {63'd0, d_rdy_b[i]}, {63'd0, m_left[i] == 6'd0});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge with the DUT not busy; returns at the negedge after the result edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] es, input logic [63:0] eu, input string nm);
      int k;
      bit seen;
      dvd = a; dvs = b; dvd_v = 1'b1; dvs_v = 1'b1;
      cyc();
      dvd_v = 1'b0; dvs_v = 1'b0; dvd = $urandom; dvs = $urandom;
      k = 0;
      seen = 1'b0;
      while (!seen && k < 40) begin
         cyc();
         k++;
         if (d_tv[0] && d_tv[1]) seen = 1'b1;
         else if (k == 16) chk({nm, "_busy_rdy"}, {60'd0, d_rdy_a, d_rdy_b}, 64'd0);
      end
      chk({nm, "_latency"}, 64'(k), 64'd32);
      chk({nm, "_signed"}, d_td[0], es);
      chk({nm, "_unsigned"}, d_td[1], eu);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         4: return 32'd0 - 32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      resetn = 1'b0;
      dvd_v = 1'b0; dvs_v = 1'b0; dvd = 32'd0; dvs = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_tvalid", {62'd0, d_tv}, 64'd0);
      chk("rst_tdata_s", d_td[0], 64'd0);
      chk("rst_tdata_u", d_td[1], 64'd0);
      chk("rst_rdy", {60'd0, d_rdy_a, d_rdy_b}, 64'hF);
      resetn = 1'b1;

      // Successive run_op calls are accepted in the DONE cycle (back-to-back).
      run_op(32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002, "d100_7");
      run_op(32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFD_FFFF_FFFF, 64'h7FFF_FFFC_0000_0001, "dm7_2");
      run_op(32'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFD_0000_0001, 64'h0000_0000_0000_0007, "d7_m2");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000, "dovf");
      run_op(32'h1234_5678, 32'd0, 64'hFFFF_FFFF_1234_5678, 64'hFFFF_FFFF_1234_5678, "ddz");

`ifdef ITER_DIV_HOLD_RESULT_EN
      repeat (22) cyc();
      chk("hold_tvalid", {62'd0, d_tv}, 64'd3);
      chk("hold_tdata", d_td[0], 64'hFFFF_FFFF_1234_5678);
`else
      cyc();
      chk("pulse_tvalid", {62'd0, d_tv}, 64'd0);
      chk("pulse_tdata", d_td[1], 64'hFFFF_FFFF_1234_5678);
`endif

      dvd = 32'd5; dvd_v = 1'b1;
      repeat (5) cyc();
      dvd_v = 1'b0; dvs = 32'd3; dvs_v = 1'b1;
      repeat (3) cyc();
      dvs_v = 1'b0;
      chk("lone_rdy", {60'd0, d_rdy_a, d_rdy_b}, 64'hF);
      run_op(32'd1000, 32'd10, 64'h00000064_00000000, 64'h00000064_00000000, "d1000_10");

      dvd = 32'hDEAD_BEEF; dvs = 32'h11; dvd_v = 1'b1; dvs_v = 1'b1;
      cyc();
      dvd_v = 1'b0; dvs_v = 1'b0;
      repeat (9) cyc();
      resetn = 1'b0;
      cyc();
      chk("midrst_tvalid", {62'd0, d_tv}, 64'd0);
      chk("midrst_tdata", d_td[0] | d_td[1], 64'd0);
      chk("midrst_rdy", {60'd0, d_rdy_a, d_rdy_b}, 64'hF);
      resetn = 1'b1;
      run_op(32'd9, 32'd3, 64'h00000003_00000000, 64'h00000003_00000000, "d9_3");

      for (int c = 0; c < 12000; c++) begin
         resetn = ($urandom_range(0, 999) != 0);
         dvd_v  = $urandom_range(0, 1) == 1;
         dvs_v  = $urandom_range(0, 1) == 1;
         dvd    = pick();
         dvs    = pick();
         cyc();
      end

      resetn = 1'b1; dvd_v = 1'b0; dvs_v = 1'b0;
      repeat (40) cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
